shift_right_align_pipe: RTL

- Pipelined, parametrised right-shift alignment unit for the FP add/sub datapath. Aligns the smaller operand's significand before the adder.
- Per operation it builds {hidden, mantissa, EXT_W zero bits}, shifts right by an 8-bit amount and folds every shifted-out 1 into a sticky LSB.
- One barrel level per pipeline register, with valid/ready backpressure and a sideband tag.
- Default parameters reproduce the 27-bit single-precision alignment format: 1 hidden bit, 23 mantissa bits, 3 extension bits.

---
 rtl/fp_align_pkg.sv | 30 +++
 rtl/shift_right_align_pipe_level.sv | 94 +++++++++
 rtl/shift_right_align_pipe.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fp_align_pkg.sv
// fp_align_pkg
// Shared constants and width-derivation helpers for the FP alignment
// shifter. DATA_W is the aligned significand width {hidden, mantissa,
// extension bits}; LEVELS is the number of barrel levels needed to cover
// every shift amount below DATA_W. Bit STICKY_IDX of the aligned word is
// always the sticky bit.
package fp_align_pkg;

  localparam int DEF_MANT_W  = 23;
  localparam int DEF_EXT_W   = 3;
  localparam int DEF_SHIFT_W = 8;
  localparam int DEF_TAG_W   = 4;
  localparam int STICKY_IDX  = 0;

  // Aligned significand width: hidden bit + stored mantissa + extension bits.
  function automatic int calc_data_w(input int mant_w, input int ext_w);
    return mant_w + 1 + ext_w;
  endfunction

  // Ceiling log2: smallest l with 2^l >= w.
  function automatic int calc_levels(input int w);
    int l;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << l) < w) l = l + 1;
    end
    return l;
  endfunction

endpackage

// File: rtl/shift_right_align_pipe_level.sv
// shift_right_level
// One registered barrel level of the alignment shifter. When the level's
// shift bit is set (and the op is not already saturated) the word moves
// right by 2^SHIFT_POS places and every 1 that falls off the bottom is
// ORed into the running sticky flag. Shift, saturation flag, tag and valid
// travel alongside the data.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   enable                 advance the register (0 = hold, pipeline stall)
//   valid/data/sticky/shift/sat/tag _in   values from the previous stage
//   valid/data/sticky/shift/sat/tag _out  registered values of this stage
module shift_right_level #(
  parameter int DATA_W     = 27,
  parameter int SHIFT_POS  = 0,
  parameter int SHIFT_BITS = 5,
  parameter int TAG_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  sticky_in,
  input  logic [SHIFT_BITS-1:0] shift_in,
  input  logic                  sat_in,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  sticky_out,
  output logic [SHIFT_BITS-1:0] shift_out,
  output logic                  sat_out,
  output logic [TAG_W-1:0]      tag_out
);

  localparam int AMT = 1 << SHIFT_POS;

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  sticky_q, sticky_d;
  logic [SHIFT_BITS-1:0] shift_q, shift_d;
  logic                  sat_q, sat_d;
  logic [TAG_W-1:0]      tag_q, tag_d;

  // Next-state: hold everything on a stall, otherwise load the previous
  // stage and apply this level's shift. Saturated ops already carry
  // zero data and their final sticky, so the shift is skipped for them.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    sticky_d = sticky_q;
    shift_d  = shift_q;
    sat_d    = sat_q;
    tag_d    = tag_q;
    if (enable) begin
      valid_d  = valid_in;
      data_d   = data_in;
      sticky_d = sticky_in;
      shift_d  = shift_in;
      sat_d    = sat_in;
      tag_d    = tag_in;
      if (shift_in[SHIFT_POS] && !sat_in) begin
        data_d   = data_in >> AMT;
        sticky_d = sticky_in | (|data_in[AMT-1:0]);
      end
    end
  end

  // Stage register; reset wipes the op so nothing in flight survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      sticky_q <= 1'b0;
      shift_q  <= '0;
      sat_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      shift_q  <= shift_d;
      sat_q    <= sat_d;
      tag_q    <= tag_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign sticky_out = sticky_q;
  assign shift_out  = shift_q;
  assign sat_out    = sat_q;
  assign tag_out    = tag_q;

endmodule

// File: rtl/shift_right_align_pipe.sv
// shift_right_align_pipe
// Pipelined right-shift alignment unit for the FP add/sub datapath. Each op
// builds {hidden, mantissa, EXT_W zeros}, is shifted right by in_shift, and
// every shifted-out 1 is folded into the sticky LSB. One barrel level per
// pipeline register, LEVELS cycles of latency, 1 op/cycle throughput, and a
// global stall when the output is valid but not accepted.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid / in_ready           input handshake (in_ready = !stall)
//   in_shift, in_mant, in_hidden  shift amount and significand fields
//   in_tag                        sideband carried with the op
//   out_valid / out_ready         output handshake
//   out_result                    aligned significand, bit 0 = sticky
//   out_tag                       tag of the op in out_result
module shift_right_align_pipe
  import fp_align_pkg::*;
#(
  parameter int MANT_W  = DEF_MANT_W,
  parameter int EXT_W   = DEF_EXT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int TAG_W   = DEF_TAG_W,
  localparam int DATA_W = calc_data_w(MANT_W, EXT_W),
  localparam int LEVELS = calc_levels(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic               in_hidden,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [TAG_W-1:0]   out_tag
);

  logic              stall;
  logic              cap_sat;
  logic              cap_sticky;
  logic [DATA_W-1:0] cap_data;

  logic              valid_s  [LEVELS];
  logic [DATA_W-1:0] data_s   [LEVELS];
  logic              sticky_s [LEVELS];
  logic [LEVELS-1:0] shift_s  [LEVELS];
  logic              sat_s    [LEVELS];
  logic [TAG_W-1:0]  tag_s    [LEVELS];

  // Every stage holds together while the finished op waits downstream.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Capture: build the unshifted format. Shift amounts with any bit at or
  // above LEVELS set are saturated here, since the barrel cannot express
  // them; the word becomes 0 and sticky records whether anything was there.
  // Bubbles are captured as all-zero so idle inputs cannot leak into sticky.
  always_comb begin
    cap_sat = 1'b0;
    for (int i = LEVELS; i < SHIFT_W; i++) begin
      cap_sat = cap_sat | in_shift[i];
    end
    cap_data   = {in_hidden, in_mant, {EXT_W{1'b0}}};
    cap_sticky = 1'b0;
    if (!in_valid) begin
      cap_data = '0;
    end else if (cap_sat) begin
      cap_sticky = |cap_data;
      cap_data   = '0;
    end
  end

  // Barrel chain: level k shifts by 2^k and registers the result.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic              v_in;
    logic [DATA_W-1:0] d_in;
    logic              st_in;
    logic [LEVELS-1:0] sh_in;
    logic              sat_in;
    logic [TAG_W-1:0]  t_in;

    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign d_in   = cap_data;
      assign st_in  = cap_sticky;
      assign sh_in  = in_shift[LEVELS-1:0];
      assign sat_in = cap_sat;
      assign t_in   = in_tag;
    end else begin : g_src
      assign v_in   = valid_s[k-1];
      assign d_in   = data_s[k-1];
      assign st_in  = sticky_s[k-1];
      assign sh_in  = shift_s[k-1];
      assign sat_in = sat_s[k-1];
      assign t_in   = tag_s[k-1];
    end

    shift_right_level #(
      .DATA_W    (DATA_W),
      .SHIFT_POS (k),
      .SHIFT_BITS(LEVELS),
      .TAG_W     (TAG_W)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (!stall),
      .valid_in  (v_in),
      .data_in   (d_in),
      .sticky_in (st_in),
      .shift_in  (sh_in),
      .sat_in    (sat_in),
      .tag_in    (t_in),
      .valid_out (valid_s[k]),
      .data_out  (data_s[k]),
      .sticky_out(sticky_s[k]),
      .shift_out (shift_s[k]),
      .sat_out   (sat_s[k]),
      .tag_out   (tag_s[k])
    );
  end

  // The last stage's shift and saturation flags have no consumer.
  logic unused_tail;
  assign unused_tail = sat_s[LEVELS-1] ^ (^shift_s[LEVELS-1]);

  // Sticky is merged into the LSB only at the output.
  assign out_valid  = valid_s[LEVELS-1];
  assign out_result = {data_s[LEVELS-1][DATA_W-1:1],
                       data_s[LEVELS-1][STICKY_IDX] | sticky_s[LEVELS-1]};
  assign out_tag    = tag_s[LEVELS-1];

endmodule
